// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer between N_REQ byte producers, with message lock.
// Latency: byte accepted on the valid&ready edge, tx_start pulses in the following cycle.
// Backpressure: req_ready is held low from accept until tx_done_tick; a stalled locked owner is dropped after LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done_tick,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic               r_lock;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_tx_data;
  logic [N_REQ-1:0]   r_grant;
  logic               w_sel_vld;
  logic [PTR_W-1:0]   w_sel_idx;
  logic               w_xfer;

  // Successor of a requester index, wrapping N_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    if (i == PTR_W'(N_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Candidate selection: locked owner only, otherwise first valid requester at or after ptr.
  // The loop runs from the farthest offset down so the nearest valid one is written last and wins.
  always_comb begin
    int j;
    j         = 0;
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    if (r_lock) begin
      w_sel_vld = req_valid[r_owner];
      w_sel_idx = r_owner;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        j = int'(r_ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        if (req_valid[j]) begin
          w_sel_vld = 1'b1;
          w_sel_idx = PTR_W'(j);
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_ARB;
    else          r_state <= w_state_nxt;
  end

  // Next state and the combinational ready; ready is masked while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    req_ready   = '0;
    case (r_state)
      ST_ARB: begin
        if (w_sel_vld && reset_n) begin
          w_xfer               = 1'b1;
          req_ready[w_sel_idx] = 1'b1;
          w_state_nxt          = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (tx_done_tick) w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
  end

  // Byte capture, grant/lock bookkeeping, rr pointer and lock idle timeout.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_lock    <= 1'b0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_grant   <= '0;
    end else if (w_xfer) begin
      r_tx_data <= req_data[{w_sel_idx, 3'b000} +: 8];
      r_last    <= req_last[w_sel_idx];
      r_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
      r_owner   <= w_sel_idx;
      r_cnt     <= '0;
    end else if (r_state == ST_WAIT && tx_done_tick) begin
      if (r_last) begin
        r_lock  <= 1'b0;
        r_grant <= '0;
        r_ptr   <= next_idx(r_owner);
      end else begin
        r_lock  <= 1'b1;
      end
    end else if (r_state == ST_ARB && r_lock && !req_valid[r_owner]) begin
      if (r_cnt == TO_LAST) begin
        r_lock  <= 1'b0;
        r_grant <= '0;
        r_ptr   <= next_idx(r_owner);
        r_cnt   <= '0;
      end else if (r_cnt != '1) begin
        r_cnt   <= r_cnt + 1'b1;
      end
    end else if (!r_lock) begin
      r_cnt <= '0;
    end
  end

  assign tx_start = (r_state == ST_START);
  assign busy     = (r_state != ST_ARB);
  assign tx_data  = r_tx_data;
  assign grant    = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round robin, message lock, lock timeout, mid-byte reset.
// Inputs are driven 2 time units after the rising edge and outputs sampled before the next edge.
// The serializer is modelled by the bench pulsing tx_done_tick a few cycles after tx_start.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int LT = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_done_tick;
  logic [N-1:0]   grant;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [7:0] d, input logic last);
    req_data[8*idx +: 8] = d;
    req_last[idx]        = last;
  endtask

  // One full byte through the arbiter: ready before the edge, start/data after, done after a short frame.
  task automatic xfer(input int idx, input logic [7:0] d, input logic drop);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    #1;
    check("ready_sel", 32'(req_ready), 32'(oh));
    tick();
    if (drop) req_valid[idx] = 1'b0;
    #1;
    check("tx_start_hi", 32'(tx_start), 32'd1);
    check("tx_data", 32'(tx_data), 32'(d));
    check("grant_own", 32'(grant), 32'(oh));
    check("ready_start", 32'(req_ready), 32'd0);
    tick();
    check("tx_start_lo", 32'(tx_start), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    tick();
    tick();
    check("tx_data_hold", 32'(tx_data), 32'(d));
    tx_done_tick = 1'b1;
    #1;
    check("ready_done", 32'(req_ready), 32'd0);
    tick();
    tx_done_tick = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '1;
    req_data     = '0;
    req_last     = '1;
    tx_done_tick = 1'b0;

    // Reset held for 3 cycles with every requester valid.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    tick();

    // Single byte from requester 2; pointer then moves to 3.
    req_valid = 4'b0100;
    set_req(2, 8'hA5, 1'b1);
    xfer(2, 8'hA5, 1'b1);
    #1;
    check("single_grant_clr", 32'(grant), 32'd0);
    check("single_busy_clr", 32'(busy), 32'd0);
    req_valid = 4'b1011;
    #1;
    check("single_next_ptr3", 32'(req_ready), 32'b1000);
    req_valid = 4'b1000;
    set_req(3, 8'h3C, 1'b1);
    xfer(3, 8'h3C, 1'b1);

    // Round robin with all four valid, single-byte messages: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + 8'h11 * i), 1'b1);
    req_valid = 4'b1111;
    for (int r = 0; r < 2 * N; r++) xfer(r % N, 8'(8'h10 + 8'h11 * (r % N)), 1'b0);
    req_valid = '0;
    tick();

    // Message lock: req0 sends 3 bytes while req1 waits.
    req_valid = 4'b0011;
    set_req(1, 8'h77, 1'b1);
    set_req(0, 8'h11, 1'b0);
    xfer(0, 8'h11, 1'b0);
    check("lock_grant_hold", 32'(grant), 32'b0001);
    set_req(0, 8'h22, 1'b0);
    xfer(0, 8'h22, 1'b0);
    set_req(0, 8'h33, 1'b1);
    xfer(0, 8'h33, 1'b1);
    xfer(1, 8'h77, 1'b1);

    // Lock timeout: req0 stalls mid-message, req2 must wait exactly LT cycles.
    req_valid = 4'b0001;
    set_req(0, 8'h5A, 1'b0);
    xfer(0, 8'h5A, 1'b1);
    req_valid = 4'b0100;
    set_req(2, 8'hC3, 1'b1);
    for (int k = 0; k < LT; k++) begin
      #1;
      check("to_ready_blocked", 32'(req_ready), 32'd0);
      check("to_grant_held", 32'(grant), 32'b0001);
      tick();
    end
    check("to_grant_drop", 32'(grant), 32'd0);
    xfer(2, 8'hC3, 1'b1);

    // Reset while waiting for the serializer abandons the byte and restarts at ptr 0.
    req_valid = 4'b0010;
    set_req(1, 8'h99, 1'b1);
    #1;
    check("mid_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    check("mid_start", 32'(tx_start), 32'd1);
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick();
    req_valid = 4'b1001;
    set_req(0, 8'hE1, 1'b1);
    set_req(3, 8'hE4, 1'b1);
    xfer(0, 8'hE1, 1'b1);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
